// File: rtl/accel_pkg.sv
// accel_pkg: shared sizing and requantization helpers for accelerator stages
package accel_pkg;
  function automatic int min_acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction
  // acc must arrive sign-extended to 64 bits; the result is already saturated to dw bits
  function automatic logic signed [63:0] requant(input logic signed [63:0] acc, input int dw, input int s);
    logic signed [64:0] t, q, hi, lo;
    t = 65'(acc) + (65'sd1 <<< (s - 1));
    q = t >>> s;
    hi = (65'sd1 <<< (dw - 1)) - 65'sd1;
    lo = -hi - 65'sd1;
    return (q > hi) ? hi[63:0] : (q < lo) ? lo[63:0] : q[63:0];
  endfunction
endpackage

// File: rtl/sa_output_aligner_column_delay_line.sv
// column_delay_line: enabled shift register with sync reset; zero depth is a wire
module column_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    logic unused;
    assign unused = ^{clk, rst, en};
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else if (en) begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/sa_output_aligner.sv
// sa_output_aligner: de-skews systolic column outputs and requantizes each aligned row
module sa_output_aligner
  import accel_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int SA_LENGTH  = 8,
  parameter int S          = 7,
  parameter int ACC_WIDTH  = 28
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [ACC_WIDTH-1:0]  acc_in    [SA_LENGTH],
  input  logic                         acc_valid [SA_LENGTH],
  output logic signed [DATA_WIDTH-1:0] out       [SA_LENGTH],
  output logic                         out_valid,
  output logic                         align_err
);
  logic [ACC_WIDTH:0] dl_q [SA_LENGTH];
  logic [SA_LENGTH-1:0] av;
  logic signed [DATA_WIDTH-1:0] qv [SA_LENGTH];
  logic all_v, mixed_v;
  if (ACC_WIDTH < min_acc_width(DATA_WIDTH, SA_LENGTH) || ACC_WIDTH > 63) begin : g_bad
    $error("sa_output_aligner: ACC_WIDTH out of range");
  end
  genvar j;
  for (j = 0; j < SA_LENGTH; j++) begin : g_col
    // earlier columns wait longer so every column of a row lands together
    column_delay_line #(.WIDTH(ACC_WIDTH + 1), .DEPTH(SA_LENGTH - 1 - j)) u_dl (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   ({acc_valid[j], acc_in[j]}),
      .q   (dl_q[j])
    );
    assign av[j] = dl_q[j][ACC_WIDTH];
    assign qv[j] = DATA_WIDTH'(requant(64'(signed'(dl_q[j][ACC_WIDTH-1:0])), DATA_WIDTH, S));
  end
  assign all_v   = &av;
  assign mixed_v = |av && !all_v;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SA_LENGTH; i++) out[i] <= '0;
      out_valid <= 1'b0;
      align_err <= 1'b0;
    end else if (en) begin
      out_valid <= all_v;
      if (all_v) out <= qv;
      if (mixed_v) align_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sa_output_aligner.sv
// tb_sa_output_aligner: table vectors, directed corner sequences and random traffic vs a time-indexed model
module tb_sa_output_aligner;
  localparam int DW = 12, N = 8, S = 7, AW = 28, HN = 2048;
  localparam longint QMAX = (64'sd1 <<< (DW - 1)) - 1;
  localparam longint QMIN = -(64'sd1 <<< (DW - 1));

  logic clk = 1'b0;
  logic rst, en;
  logic signed [AW-1:0] acc_in [N];
  logic acc_valid [N];
  logic signed [DW-1:0] out [N];
  logic out_valid, align_err;

  always #5 clk = ~clk;

  sa_output_aligner #(.DATA_WIDTH(DW), .SA_LENGTH(N), .S(S), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .acc_in(acc_in), .acc_valid(acc_valid),
    .out(out), .out_valid(out_valid), .align_err(align_err)
  );

  int errors = 0, checks = 0;
  longint ha [HN][N];
  bit hv [HN][N];
  int ec = 0, base = 0;
  longint exp_out [N];
  bit exp_valid, exp_err;
  longint rv [16][N];
  int rage [16], rlate [16];
  bit ract [16];
  longint nv [N];

  typedef struct { longint acc; longint q; } vec_t;
  vec_t tbl [10];

  function automatic longint ref_q(input longint a);
    longint t;
    t = a + (64'sd1 <<< (S - 1));
    t = (t >= 0) ? t / 128 : -((-t + 127) / 128);
    return (t > QMAX) ? QMAX : (t < QMIN) ? QMIN : t;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int bad;
    bad = -1;
    chk("out_valid", longint'(out_valid), longint'(exp_valid));
    chk("align_err", longint'(align_err), longint'(exp_err));
    for (int j = 0; j < N; j++) if (bad < 0 && longint'(out[j]) != exp_out[j]) bad = j;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL out[%0d]: got %0d expected %0d at %0t", bad, out[bad], exp_out[bad], $time);
    end
  endtask

  task automatic start_row(input int late);
    for (int s = 0; s < 16; s++) begin
      if (!ract[s]) begin
        for (int j = 0; j < N; j++) rv[s][j] = nv[j];
        rage[s] = 0;
        rlate[s] = late;
        ract[s] = 1'b1;
        break;
      end
    end
  endtask

  task automatic step(input bit e);
    bit pv [N];
    longint pa [N];
    bit all, any, v;
    int idx;
    for (int j = 0; j < N; j++) begin
      pv[j] = 1'b0;
      pa[j] = 0;
    end
    for (int s = 0; s < 16; s++)
      if (ract[s])
        for (int j = 0; j < N; j++)
          if (rage[s] == j + ((j == rlate[s]) ? 1 : 0)) begin
            pv[j] = 1'b1;
            pa[j] = rv[s][j];
          end
    en = e;
    for (int j = 0; j < N; j++) begin
      acc_in[j] = e ? AW'(pa[j]) : AW'($urandom);
      acc_valid[j] = e ? pv[j] : 1'($urandom);
    end
    if (e) begin
      for (int j = 0; j < N; j++) begin
        hv[ec][j] = pv[j];
        ha[ec][j] = pa[j];
      end
      all = 1'b1;
      any = 1'b0;
      for (int j = 0; j < N; j++) begin
        idx = ec - (N - 1 - j);
        v = (idx >= base) ? hv[idx][j] : 1'b0;
        all &= v;
        any |= v;
        pa[j] = v ? ha[idx][j] : 0;
      end
      exp_valid = all;
      if (all) for (int j = 0; j < N; j++) exp_out[j] = ref_q(pa[j]);
      if (any && !all) exp_err = 1'b1;
      ec++;
      for (int s = 0; s < 16; s++)
        if (ract[s]) begin
          rage[s]++;
          if (rage[s] > N) ract[s] = 1'b0;
        end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'($urandom);
    for (int j = 0; j < N; j++) begin
      acc_in[j] = AW'($urandom);
      acc_valid[j] = 1'b1;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int j = 0; j < N; j++) exp_out[j] = 0;
    exp_valid = 1'b0;
    exp_err = 1'b0;
    base = ec;
    for (int s = 0; s < 16; s++) ract[s] = 1'b0;
    compare_all();
  endtask

  task automatic run_until_valid(input int maxn, output int k);
    k = 0;
    while (k < maxn) begin
      step(1'b1);
      k++;
      if (out_valid) break;
    end
  endtask

  task automatic rand_row();
    logic signed [AW-1:0] w;
    for (int j = 0; j < N; j++) begin
      w = AW'($urandom);
      nv[j] = ($urandom_range(0, 3) == 0) ? longint'(w) : longint'($urandom_range(0, 600000)) - 300000;
    end
  endtask

  initial begin
    int k, vcnt, first, last;
    longint held [N];
    longint v0 [N];
    v0 = '{0, 400, 517, -512, -1, -2048, 2047, 52};
    tbl = '{'{51263, 400}, '{51264, 401}, '{-192, -1}, '{-193, -2}, '{63, 0}, '{64, 1},
            '{262216, 2047}, '{-262272, -2048}, '{(64'sd1 <<< (AW - 1)) - 1, 2047}, '{-(64'sd1 <<< (AW - 1)), -2048}};
    rst = 1'b1;
    en = 1'b0;
    for (int j = 0; j < N; j++) begin
      acc_in[j] = '0;
      acc_valid[j] = 1'b0;
    end
    for (int s = 0; s < 16; s++) ract[s] = 1'b0;
    do_reset();
    do_reset();

    for (int j = 0; j < N; j++) nv[j] = v0[j] * 128;
    start_row(-1);
    run_until_valid(20, k);
    chk("aligned_latency", k, 8);
    for (int j = 0; j < N; j++) chk("aligned_value", longint'(out[j]), v0[j]);
    step(1'b1);
    chk("aligned_one_cycle", longint'(out_valid), 0);

    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < N; j++) nv[j] = 0;
      nv[1] = tbl[i].acc;
      start_row(-1);
      run_until_valid(20, k);
      chk("tbl_latency", k, 8);
      chk("tbl_requant", longint'(out[1]), tbl[i].q);
    end

    vcnt = 0;
    first = -1;
    last = -1;
    for (int i = 0; i < 14; i++) begin
      if (i < 4) begin
        rand_row();
        start_row(-1);
      end
      step(1'b1);
      if (out_valid) begin
        vcnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("stream_count", vcnt, 4);
    chk("stream_contiguous", last - first, 3);

    rand_row();
    start_row(-1);
    repeat (3) step(1'b1);
    repeat (3) step(1'b0);
    run_until_valid(20, k);
    chk("stall_latency", k + 6, 11);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 8) begin
        if ($urandom_range(0, 9) < 5) begin
          rand_row();
          start_row(-1);
        end
        step(1'b1);
      end else step(1'b0);
    end
    repeat (N + 2) step(1'b1);

    for (int j = 0; j < N; j++) held[j] = longint'(out[j]);
    rand_row();
    start_row(3);
    vcnt = 0;
    repeat (12) begin
      step(1'b1);
      if (out_valid) vcnt++;
    end
    chk("skew_err", longint'(align_err), 1);
    chk("skew_no_valid", vcnt, 0);
    for (int j = 0; j < N; j++) chk("skew_out_held", longint'(out[j]), held[j]);
    rand_row();
    start_row(-1);
    run_until_valid(20, k);
    chk("post_skew_latency", k, 8);
    chk("post_skew_err_sticky", longint'(align_err), 1);

    rand_row();
    start_row(-1);
    repeat (5) step(1'b1);
    do_reset();
    chk("rst_err_clear", longint'(align_err), 0);
    vcnt = 0;
    repeat (12) begin
      step(1'b1);
      if (out_valid) vcnt++;
    end
    chk("rst_no_partial", vcnt, 0);
    for (int j = 0; j < N; j++) nv[j] = v0[N - 1 - j] * 128 + 63;
    start_row(-1);
    run_until_valid(20, k);
    chk("post_rst_latency", k, 8);
    chk("post_rst_value", longint'(out[0]), 52);
    chk("post_rst_err", longint'(align_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
